pipelined_muldiv_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Registers every result and adds iterative multiply and divide, with results written to HI/LO registers.
- Sits in the execute stage. The stage stalls through `in_ready` and `out_ready` instead of relying on combinational settling.
- Compared with the earlier ALU:
  - SLT is genuinely signed and SLTU unsigned.
  - Overflow is defined for every op.
  - `zero` is independent of overflow.

---
 rtl/pipelined_muldiv_alu.sv | 225 ++++++++++++++++++++++
 tb/tb_pipelined_muldiv_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_muldiv_alu.sv
// Execute-stage ALU with registered, handshaked results and iterative
// shift-add multiply / restoring divide that write HI/LO.
module pipelined_muldiv_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mb_q, mb_d, a_q, a_d, b_q, b_d;
    logic               div_q, div_d, sgn_q, sgn_d, neg_q, neg_d, rneg_q, rneg_d;
    logic               out_valid_q, out_valid_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;

    logic               accept, slot_free;
    logic [WIDTH-1:0]   sc_res, sum, diff;
    logic               sc_ovf;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, fix_hi, fix_lo;
    logic               fix_ovf;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == S_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;

    always_comb begin
        sum    = a + b;
        diff   = a - b;
        sc_res = '0;
        sc_ovf = 1'b0;
        case (op)
            4'b0000: sc_res = hi_q;
            4'b0001: begin
                sc_res = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0010: sc_res = sum;
            4'b0011: sc_res = a & b;
            4'b0100: sc_res = a | b;
            4'b0101: sc_res = ~(a | b);
            4'b0110: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b0111: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1000: sc_res = b << shamt;
            4'b1001: sc_res = b >> shamt;
            4'b1010: begin
                sc_res = diff;
                sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b1011: sc_res = diff;
            4'b1100: sc_res = $signed(b) >>> shamt;
            4'b1101: sc_res = {a[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: sc_res = '0;
        endcase
    end

    // One iteration: multiply adds the multiplicand into the upper half and
    // shifts right; divide shifts the {rem,quo} pair left and trial-subtracts.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, mb_q};
        if (!div_q)
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        else if (rem_diff[WIDTH])
            acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            acc_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        mag_a   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        prod    = neg_q ? -acc_q : acc_q;
        quo     = acc_q[WIDTH-1:0];
        rem     = acc_q[2*WIDTH-1:WIDTH];
        fix_hi  = prod[2*WIDTH-1:WIDTH];
        fix_lo  = prod[WIDTH-1:0];
        fix_ovf = 1'b0;
        if (div_q) begin
            if (b_q == '0) begin
                fix_lo  = '1;
                fix_hi  = a_q;
                fix_ovf = 1'b1;
            end else if (sgn_q && a_q == MIN_VAL && b_q == '1) begin
                fix_lo  = MIN_VAL;
                fix_hi  = '0;
                fix_ovf = 1'b1;
            end else begin
                fix_lo = neg_q ? -quo : quo;
                fix_hi = rneg_q ? -rem : rem;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mb_d        = mb_q;
        a_d         = a_q;
        b_d         = b_q;
        div_d       = div_q;
        sgn_d       = sgn_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                if (op[3:1] == 3'b111) begin
                    state_d = S_PREP;
                    a_d     = a;
                    b_d     = b;
                    div_d   = op[0];
                    sgn_d   = sgn;
                end else begin
                    out_valid_d = 1'b1;
                    result_d    = sc_res;
                    zero_d      = (sc_res == '0);
                    ovf_d       = sc_ovf;
                end
            end
            S_PREP: begin
                acc_d   = {{WIDTH{1'b0}}, mag_a};
                mb_d    = mag_b;
                neg_d   = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d  = sgn_q && a_q[WIDTH-1];
                cnt_d   = CNTW'(WIDTH - 1);
                state_d = S_CALC;
            end
            S_CALC: begin
                acc_d = acc_step;
                if (cnt_q == '0)
                    state_d = S_FIX;
                else
                    cnt_d = cnt_q - CNTW'(1);
            end
            default: if (slot_free) begin
                hi_d        = fix_hi;
                lo_d        = fix_lo;
                result_d    = fix_lo;
                zero_d      = (fix_lo == '0);
                ovf_d       = fix_ovf;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mb_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            div_q       <= 1'b0;
            sgn_q       <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mb_q        <= mb_d;
            a_q         <= a_d;
            b_q         <= b_d;
            div_q       <= div_d;
            sgn_q       <= sgn_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_pipelined_muldiv_alu.sv
// Directed bench for pipelined_muldiv_alu at WIDTH=32: vector table for the
// single-cycle ops plus hand-written mult/div, backpressure and reset sequences.
module tb_pipelined_muldiv_alu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sgn, out_valid, out_ready, zero, overflow;
    logic [3:0]  op;
    logic [31:0] a, b, result, hi, lo;
    logic [4:0]  shamt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_muldiv_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sgn(sgn), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .overflow(overflow), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic single(input string nm, input logic [3:0] iop, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [4:0] ish,
                          input logic [31:0] eres, input logic eovf);
        @(negedge clk);
        op = iop; a = ia; b = ib; shamt = ish; sgn = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, ".valid"}, 64'(out_valid), 64'(1'b1));
        chk({nm, ".result"}, 64'(result), 64'(eres));
        chk({nm, ".zero"}, 64'(zero), 64'(eres == 32'd0));
        chk({nm, ".ovf"}, 64'(overflow), 64'(eovf));
    endtask

    task automatic run_md(input string nm, input logic isgn, input logic idiv,
                          input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic eovf);
        int n;
        int bad;
        logic [31:0] hi0, lo0;
        @(negedge clk);
        op = idiv ? 4'hF : 4'hE; sgn = isgn; a = ia; b = ib; in_valid = 1'b1;
        chk({nm, ".ready_in"}, 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        n = 0; bad = 0; hi0 = hi; lo0 = lo;
        while (!out_valid && n < 100) begin
            if (in_ready || hi !== hi0 || lo !== lo0) bad++;
            @(negedge clk);
            n++;
        end
        chk({nm, ".latency"}, 64'(n), 64'(34));
        chk({nm, ".busy"}, 64'(bad), 64'(0));
        chk({nm, ".lo"}, 64'(lo), 64'(elo));
        chk({nm, ".hi"}, 64'(hi), 64'(ehi));
        chk({nm, ".result"}, 64'(result), 64'(elo));
        chk({nm, ".ovf"}, 64'(overflow), 64'(eovf));
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 32'h0,        32'h0,        5'd0,  32'h0,        1'b0}; // mfhi after reset
        vecs[1]  = '{4'b0001, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1};
        vecs[2]  = '{4'b0010, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0};
        vecs[3]  = '{4'b1010, 32'h5,        32'h5,        5'd0,  32'h0,        1'b0};
        vecs[4]  = '{4'b1010, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b1};
        vecs[5]  = '{4'b1011, 32'h0,        32'h1,        5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0};
        vecs[7]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0};
        vecs[8]  = '{4'b0101, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{4'b1000, 32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0};
        vecs[10] = '{4'b1001, 32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0};
        vecs[11] = '{4'b1100, 32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0};
        vecs[12] = '{4'b1101, 32'h1234ABCD, 32'h0,        5'd0,  32'hABCD0000, 1'b0};
        vecs[13] = '{4'b0111, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0};
        vecs[14] = '{4'b0110, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0};
        vecs[15] = '{4'b0111, 32'h1,        32'hFFFFFFFF, 5'd0,  32'h0,        1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; sgn = 1'b0;
        a = '0; b = '0; shamt = '0;
        #12;
        chk("rst.valid", 64'(out_valid), 64'(1'b0));
        chk("rst.ready", 64'(in_ready), 64'(1'b1));
        chk("rst.result", 64'(result), 64'(0));
        chk("rst.hilo", {hi, lo}, 64'(0));
        chk("rst.flags", 64'({zero, overflow}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].sh, vecs[i].res, vecs[i].ovf);

        run_md("mult_s", 1'b1, 1'b0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
        run_md("mult_u", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        run_md("div_s", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        single("mfhi", 4'b0000, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
        run_md("div_u", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_md("div_0", 1'b0, 1'b1, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        run_md("div_min", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1);

        // Backpressure: hold the add result for 5 cycles, then release with a request waiting.
        @(negedge clk);
        op = 4'b0001; a = 32'd2; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("bp.first", 64'(result), 64'(5));
        a = 32'd10; b = 32'd20; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp.hold%0d", i), {31'(0), out_valid, result}, {31'(0), 1'b1, 32'd5});
            chk($sformatf("bp.stall%0d", i), 64'(in_ready), 64'(1'b0));
        end
        out_ready = 1'b1;
        #1;
        chk("bp.ready", 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.next", {31'(0), out_valid, result}, {31'(0), 1'b1, 32'd30});

        // Reset in the middle of a multiply.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op = 4'hE; sgn = 1'b0; a = 32'd3; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort.busy", 64'(in_ready), 64'(1'b0));
        rst_n = 1'b0;
        #1;
        chk("abort.outs", {28'(0), out_valid, zero, overflow, in_ready, result},
            {28'(0), 4'b0001, 32'd0});
        chk("abort.hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        single("post_sub", 4'b1010, 32'd5, 32'd5, 5'd0, 32'd0, 1'b0);
        repeat (40) @(negedge clk);
        chk("abort.idle", {31'(0), out_valid, 32'(0)}, 64'(0));
        chk("abort.hilo2", {hi, lo}, 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
